uart_rx: RTL and testbench

8N1 UART receiver: the receive-side counterpart of the team's UART transmitter. It oversamples the asynchronous serial input at 16x the baud rate, validates the start bit, and shifts in 8 data bits LSB-first. It checks the stop bit, then presents the byte with a one-cycle valid strobe. `rx_int` is high for the whole reception and falls at frame end, so its falling edge can trigger the transmitter directly for loopback/echo.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_tick.sv | 36 +++
 rtl/uart_rx.sv | 163 ++++++++++++++++
 tb/tb_uart_rx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, framing constants and
// the baud divider computation used by both the receiver and transmitter.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  // Clocks per oversample tick; integer truncation.
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks. A synchronous
// clear restarts the count so tick phase can be aligned to an external event.
module uart_baud_tick #(
  parameter int DIV = 325
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: wrap at DIV-1, restart on clear.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  // Divider counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST) && !clear;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling. The line is synchronized, a
// falling edge starts a frame, the start bit is re-checked at mid-bit and
// data/stop bits are sampled every 16 ticks after that.
// Handshake: rx_valid is a one-cycle strobe with rx_data stable from that
// cycle until the next strobe; there is no ready, so the consumer must take
// the byte before the next rx_valid or it is overwritten.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rs232_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_int,
  output logic                 frame_err,
  output rx_state_e            rx_state
);

  localparam int         DIV      = calc_div(CLK_FREQ, BAUD);
  localparam logic [3:0] SC_MID   = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] SC_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic                 sync1_q, rxd_s_q, rxd_d_q;
  logic                 fall;
  logic                 tick;
  logic                 clear;
  rx_state_e            state_q, state_d;
  logic [3:0]           sc_q, sc_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 int_q, int_d;
  logic                 ferr_q, ferr_d;

  // Two-flop synchronizer plus a delayed copy for edge detection; idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxd_s_q <= 1'b1;
      rxd_d_q <= 1'b1;
    end else begin
      sync1_q <= rs232_rx;
      rxd_s_q <= sync1_q;
      rxd_d_q <= rxd_s_q;
    end
  end

  assign fall = rxd_d_q & ~rxd_s_q;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .tick  (tick)
  );

  // Receive FSM next-state, datapath updates and output strobes.
  always_comb begin
    state_d = state_q;
    sc_d    = tick ? (sc_q + 4'd1) : sc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    int_d   = int_q;
    clear   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bit_d = '0;
        if (fall) begin
          state_d = ST_START;
          int_d   = 1'b1;
          clear   = 1'b1;
          sc_d    = '0;
        end
      end
      ST_START: begin
        // Re-check the line at mid start bit to reject glitches.
        if (tick && (sc_q == SC_MID)) begin
          if (!rxd_s_q) begin
            state_d = ST_DATA;
            sc_d    = '0;
            bit_d   = '0;
          end else begin
            state_d = ST_IDLE;
            int_d   = 1'b0;
          end
        end
      end
      ST_DATA: begin
        if (tick && (sc_q == SC_LAST)) begin
          shift_d = {rxd_s_q, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == LAST_BIT) begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (tick && (sc_q == SC_LAST)) begin
          int_d = 1'b0;
          if (rxd_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        // Line held low: wait for it to return idle before re-arming.
        if (rxd_s_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        int_d   = 1'b0;
      end
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sc_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      int_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      int_q   <= int_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_int    = int_q;
  assign frame_err = ferr_q;
  assign rx_state  = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial driver tasks, a negedge monitor
// with an expected-byte queue, and directed scenarios including false start,
// framing error, mid-frame reset and baud offset.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CLK_FREQ   = 1_600_000;
  localparam int BAUD       = 10_000;
  localparam int DIV        = 10;              // 1_600_000 / (10_000 * 16)
  localparam int BIT_CLKS   = 16 * DIV;
  localparam int FRAME_CLKS = (19 * BIT_CLKS) / 2;  // 9.5 bits from rx_int rise
  localparam int RISE_LAT   = 3;

  logic      clk;
  logic      rst;
  logic      rs232_rx;
  logic [7:0] rx_data;
  logic      rx_valid;
  logic      rx_int;
  logic      frame_err;
  rx_state_e rx_state;

  logic [7:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int rise_cyc = 0;
  int int_fall_cyc = 0;
  int last_gap = 0;
  int rise_cnt = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int push_cnt = 0;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rs232_rx  (rs232_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_int    (rx_int),
    .frame_err (frame_err),
    .rx_state  (rx_state)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drivers: called at posedge+1, return at posedge+1
  task automatic drive_level(input logic v, input int clks);
    rs232_rx = v;
    repeat (clks) @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input int bc);
    fall_cyc = cyc;
    drive_level(1'b0, bc);
  endtask

  task automatic drive_data(input logic [7:0] d, input int bc);
    for (int i = 0; i < 8; i++) drive_level(d[i], bc);
  endtask

  task automatic send_frame(input logic [7:0] d, input int bc);
    exp_q.push_back(d);
    push_cnt++;
    drive_start(bc);
    drive_data(d, bc);
    drive_level(1'b1, bc);
  endtask

  // Monitor / scoreboard
  initial begin
    logic int_prev, valid_prev, ferr_prev;
    logic [7:0] exp;
    int_prev = 1'b0; valid_prev = 1'b0; ferr_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        int_prev = 1'b0; valid_prev = 1'b0; ferr_prev = 1'b0;
      end else begin
        if (rx_int && !int_prev) begin
          rise_cnt++;
          last_gap = cyc - int_fall_cyc;
          rise_cyc = cyc;
          check("int_rise_latency", cyc - fall_cyc, RISE_LAT);
        end
        if (!rx_int && int_prev) int_fall_cyc = cyc;
        if (rx_valid) begin
          valid_cnt++;
          check("valid_ferr_exclusive", frame_err, 0);
          check("valid_width", valid_prev, 0);
          check("int_falls_with_valid", {int_prev, rx_int}, 2'b10);
          check("frame_len_valid", cyc - rise_cyc, FRAME_CLKS);
          check("exp_pending", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check("rx_data", rx_data, exp);
          end
        end
        if (frame_err) begin
          ferr_cnt++;
          check("ferr_width", ferr_prev, 0);
          check("int_falls_with_ferr", {int_prev, rx_int}, 2'b10);
          check("frame_len_ferr", cyc - rise_cyc, FRAME_CLKS);
        end
        int_prev = rx_int; valid_prev = rx_valid; ferr_prev = frame_err;
      end
    end
  end

  // Directed scenarios
  initial begin
    int v0, r0, f0;
    int bcs[2];
    logic [7:0] pats[3];
    logic [7:0] d;
    bcs[0] = BIT_CLKS + BIT_CLKS / 40;   // +2.5 %
    bcs[1] = BIT_CLKS - BIT_CLKS / 40;   // -2.5 %
    pats[0] = 8'h00; pats[1] = 8'hFF; pats[2] = 8'h5A;

    rst = 1'b1;
    rs232_rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_int", rx_int, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_state", 32'(rx_state), 32'(ST_IDLE));
    rst = 1'b0;
    drive_level(1'b1, BIT_CLKS);

    // Single byte
    v0 = valid_cnt;
    send_frame(8'h55, BIT_CLKS);
    drive_level(1'b1, BIT_CLKS);
    check("t55_valid_count", valid_cnt - v0, 1);
    check("t55_data", rx_data, 8'h55);
    check("t55_no_ferr", ferr_cnt, 0);

    // Back-to-back frames with one stop bit
    v0 = valid_cnt;
    send_frame(8'hA3, BIT_CLKS);
    send_frame(8'h0F, BIT_CLKS);
    drive_level(1'b1, BIT_CLKS);
    check("b2b_valid_count", valid_cnt - v0, 2);
    check("b2b_gap_le_bit", last_gap <= BIT_CLKS, 1);
    check("b2b_last_data", rx_data, 8'h0F);

    // 3-tick glitch on idle line
    v0 = valid_cnt; r0 = rise_cnt;
    drive_start(3 * DIV);
    drive_level(1'b1, 2 * BIT_CLKS);
    check("glitch_int_pulse", rise_cnt - r0, 1);
    check("glitch_no_valid", valid_cnt - v0, 0);
    check("glitch_int_low", rx_int, 0);
    check("glitch_state_idle", 32'(rx_state), 32'(ST_IDLE));

    // Framing error with stop held low for two bit times
    send_frame(8'h3C, BIT_CLKS);
    f0 = ferr_cnt; v0 = valid_cnt;
    drive_start(BIT_CLKS);
    drive_data(8'h81, BIT_CLKS);
    drive_level(1'b0, BIT_CLKS + BIT_CLKS / 2);
    check("ferr_pulse", ferr_cnt - f0, 1);
    check("ferr_state_break", 32'(rx_state), 32'(ST_BREAK));
    check("ferr_int_low", rx_int, 0);
    check("ferr_data_kept", rx_data, 8'h3C);
    check("ferr_no_valid", valid_cnt - v0, 0);
    drive_level(1'b0, BIT_CLKS / 2);
    drive_level(1'b1, BIT_CLKS);
    check("break_exit_idle", 32'(rx_state), 32'(ST_IDLE));
    send_frame(8'h7E, BIT_CLKS);
    drive_level(1'b1, BIT_CLKS);
    check("after_break_data", rx_data, 8'h7E);

    // Reset during data bit 4
    d = 8'h99;
    drive_start(BIT_CLKS);
    for (int i = 0; i < 4; i++) drive_level(d[i], BIT_CLKS);
    drive_level(d[4], BIT_CLKS / 2);
    check("pre_reset_int_high", rx_int, 1);
    rst = 1'b1;
    #1;
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_rx_valid", rx_valid, 0);
    check("midrst_rx_int", rx_int, 0);
    check("midrst_frame_err", frame_err, 0);
    check("midrst_state", 32'(rx_state), 32'(ST_IDLE));
    rs232_rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    drive_level(1'b1, 2 * BIT_CLKS);
    send_frame(8'hC6, BIT_CLKS);
    drive_level(1'b1, BIT_CLKS);
    check("post_reset_data", rx_data, 8'hC6);

    // Baud offset tolerance
    f0 = ferr_cnt;
    for (int b = 0; b < 2; b++) begin
      for (int p = 0; p < 3; p++) begin
        send_frame(pats[p], bcs[b]);
        drive_level(1'b1, $urandom_range(BIT_CLKS / 4, BIT_CLKS));
        check("offset_data", rx_data, pats[p]);
      end
    end
    check("offset_no_ferr", ferr_cnt - f0, 0);

    // Final report
    drive_level(1'b1, BIT_CLKS);
    check("exp_q_drained", exp_q.size(), 0);
    check("valid_total", valid_cnt, push_cnt);
    check("ferr_total", ferr_cnt, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
